// File: rtl/vend_dispense.sv
// Dispense stage of the vending machine: checks the deposit against PRICE,
// pulses the item output, returns change greedily one coin per cycle, then clears the upstream accumulator.
module vend_dispense #(
    parameter int PRICE = 20,
    parameter int DEP_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [DEP_W-1:0] deposit_i,
    input  logic             buy_i,
    input  logic             cancel_i,
    output logic             soda_o,
    output logic             ret_nickle_o,
    output logic             ret_dime_o,
    output logic             ret_quarter_o,
    output logic             clear_o,
    output logic             busy_o,
    output logic [DEP_W-1:0] change_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_VEND   = 2'd1,
        S_RETURN = 2'd2,
        S_CLEAR  = 2'd3
    } state_t;

    localparam logic [DEP_W-1:0] C_PRICE   = DEP_W'(PRICE);
    localparam logic [DEP_W-1:0] C_QUARTER = DEP_W'(25);
    localparam logic [DEP_W-1:0] C_DIME    = DEP_W'(10);
    localparam logic [DEP_W-1:0] C_NICKLE  = DEP_W'(5);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DEP_W-1:0] r_change;
    logic [DEP_W-1:0] w_change_nxt;
    logic [DEP_W-1:0] w_change_ret;
    logic             w_coin_q;
    logic             w_coin_d;
    logic             w_coin_n;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= S_IDLE;
            r_change <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_change <= w_change_nxt;
        end
    end

    // Greedy coin choice from the owed change; a sub-nickel residue is simply dropped.
    always_comb begin
        w_coin_q     = 1'b0;
        w_coin_d     = 1'b0;
        w_coin_n     = 1'b0;
        w_change_ret = '0;
        if (r_change >= C_QUARTER) begin
            w_coin_q     = 1'b1;
            w_change_ret = r_change - C_QUARTER;
        end else if (r_change >= C_DIME) begin
            w_coin_d     = 1'b1;
            w_change_ret = r_change - C_DIME;
        end else if (r_change >= C_NICKLE) begin
            w_coin_n     = 1'b1;
            w_change_ret = r_change - C_NICKLE;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_change_nxt = r_change;
        case (r_state)
            S_IDLE: begin
                if (cancel_i) begin
                    if (deposit_i != '0) begin
                        w_change_nxt = deposit_i;
                        w_state_nxt  = S_RETURN;
                    end
                end else if (buy_i && (deposit_i >= C_PRICE)) begin
                    w_change_nxt = deposit_i - C_PRICE;
                    w_state_nxt  = S_VEND;
                end
            end
            S_VEND: begin
                w_state_nxt = (r_change != '0) ? S_RETURN : S_CLEAR;
            end
            S_RETURN: begin
                w_change_nxt = w_change_ret;
                if (w_change_ret == '0) begin
                    w_state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_change_nxt = '0;
                w_state_nxt  = S_IDLE;
            end
            default: begin
                w_change_nxt = '0;
                w_state_nxt  = S_IDLE;
            end
        endcase
    end

    // Outputs depend on registered state only, never directly on inputs.
    assign soda_o        = (r_state == S_VEND);
    assign ret_quarter_o = (r_state == S_RETURN) && w_coin_q;
    assign ret_dime_o    = (r_state == S_RETURN) && w_coin_d;
    assign ret_nickle_o  = (r_state == S_RETURN) && w_coin_n;
    assign clear_o       = (r_state == S_CLEAR);
    assign busy_o        = (r_state != S_IDLE);
    assign change_o      = r_change;

endmodule

// File: tb/tb_vend_dispense.sv
// Directed bench for vend_dispense with PRICE=20, DEP_W=6; expected flags and change are hand-computed.
module tb_vend_dispense;

    localparam int DEP_W = 6;

    // Flag vector order: {soda, quarter, dime, nickle, clear, busy}
    localparam logic [5:0] F_IDLE = 6'b000000;
    localparam logic [5:0] F_VEND = 6'b100001;
    localparam logic [5:0] F_QTR  = 6'b010001;
    localparam logic [5:0] F_DIME = 6'b001001;
    localparam logic [5:0] F_NICK = 6'b000101;
    localparam logic [5:0] F_NONE = 6'b000001;
    localparam logic [5:0] F_CLR  = 6'b000011;

    logic             clk_i;
    logic             rst_ni;
    logic [DEP_W-1:0] deposit_i;
    logic             buy_i;
    logic             cancel_i;
    logic             soda_o;
    logic             ret_nickle_o;
    logic             ret_dime_o;
    logic             ret_quarter_o;
    logic             clear_o;
    logic             busy_o;
    logic [DEP_W-1:0] change_o;
    logic [5:0]       w_flags;

    int n_chk = 0;
    int n_err = 0;

    vend_dispense #(.PRICE(20), .DEP_W(DEP_W)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .deposit_i     (deposit_i),
        .buy_i         (buy_i),
        .cancel_i      (cancel_i),
        .soda_o        (soda_o),
        .ret_nickle_o  (ret_nickle_o),
        .ret_dime_o    (ret_dime_o),
        .ret_quarter_o (ret_quarter_o),
        .clear_o       (clear_o),
        .busy_o        (busy_o),
        .change_o      (change_o)
    );

    assign w_flags = {soda_o, ret_quarter_o, ret_dime_o, ret_nickle_o, clear_o, busy_o};

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [5:0] exp_f, input logic [DEP_W-1:0] exp_c);
        chk({tag, "_flags"}, 32'(w_flags), 32'(exp_f));
        chk({tag, "_chg"}, 32'(change_o), 32'(exp_c));
    endtask

    task automatic cyc(input string tag, input logic [5:0] exp_f, input logic [DEP_W-1:0] exp_c);
        @(posedge clk_i);
        #1;
        chk_out(tag, exp_f, exp_c);
    endtask

    task automatic idle_inputs();
        buy_i     = 1'b0;
        cancel_i  = 1'b0;
        deposit_i = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0;
        idle_inputs();

        // Reset held: everything zero, even with a valid buy presented
        repeat (2) @(posedge clk_i);
        #1;
        chk_out("rst_hold", F_IDLE, 6'd0);
        buy_i     = 1'b1;
        deposit_i = 6'd40;
        cyc("rst_hold_buy", F_IDLE, 6'd0);
        rst_ni = 1'b1;
        cyc("rst_vend", F_VEND, 6'd20);
        idle_inputs();
        cyc("rst_dime1", F_DIME, 6'd20);
        cyc("rst_dime2", F_DIME, 6'd10);
        cyc("rst_clr", F_CLR, 6'd0);
        cyc("rst_idle", F_IDLE, 6'd0);

        // Exact price
        buy_i = 1'b1; deposit_i = 6'd20;
        cyc("exact_vend", F_VEND, 6'd0);
        idle_inputs();
        cyc("exact_clr", F_CLR, 6'd0);
        cyc("exact_idle", F_IDLE, 6'd0);

        // Change 40 -> quarter, dime, nickle; inputs during busy are ignored
        buy_i = 1'b1; deposit_i = 6'd60;
        cyc("chg_vend", F_VEND, 6'd40);
        cancel_i = 1'b1; deposit_i = 6'd35;
        cyc("chg_qtr", F_QTR, 6'd40);
        cyc("chg_dime", F_DIME, 6'd15);
        cyc("chg_nick", F_NICK, 6'd5);
        idle_inputs();
        cyc("chg_clr", F_CLR, 6'd0);
        cyc("chg_idle", F_IDLE, 6'd0);

        // Insufficient funds, buy held 3 cycles; then one cent short
        buy_i = 1'b1; deposit_i = 6'd15;
        cyc("low_1", F_IDLE, 6'd0);
        cyc("low_2", F_IDLE, 6'd0);
        cyc("low_3", F_IDLE, 6'd0);
        deposit_i = 6'd19;
        cyc("low_19", F_IDLE, 6'd0);
        idle_inputs();

        // Cancel wins over buy
        buy_i = 1'b1; cancel_i = 1'b1; deposit_i = 6'd35;
        cyc("can_qtr", F_QTR, 6'd35);
        idle_inputs();
        cyc("can_dime", F_DIME, 6'd10);
        cyc("can_clr", F_CLR, 6'd0);
        cyc("can_idle", F_IDLE, 6'd0);

        // Cancel with empty deposit does nothing, even with buy high
        cancel_i = 1'b1; buy_i = 1'b1; deposit_i = 6'd0;
        cyc("can_zero", F_IDLE, 6'd0);
        idle_inputs();

        // Non-coin residue: 22-20=2 gives a coinless RETURN cycle
        buy_i = 1'b1; deposit_i = 6'd22;
        cyc("res_vend", F_VEND, 6'd2);
        idle_inputs();
        cyc("res_ret", F_NONE, 6'd2);
        cyc("res_clr", F_CLR, 6'd0);
        cyc("res_idle", F_IDLE, 6'd0);

        // Maximum deposit, then asynchronous reset during the first RETURN cycle
        buy_i = 1'b1; deposit_i = 6'd63;
        cyc("mrst_vend", F_VEND, 6'd43);
        idle_inputs();
        cyc("mrst_qtr", F_QTR, 6'd43);
        #2;
        rst_ni = 1'b0;
        #1;
        chk_out("mrst_async", F_IDLE, 6'd0);
        cyc("mrst_held", F_IDLE, 6'd0);
        rst_ni = 1'b1;
        cyc("mrst_rel1", F_IDLE, 6'd0);
        cyc("mrst_rel2", F_IDLE, 6'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/vend_dispense.md
Name: vend_dispense

Overview:
- Downstream stage of the coin-accepting block in the vending-machine datapath.
- Consumes the running deposit total. On a purchase request it checks the total against the item price, pulses the item-dispense output, and returns change one coin per cycle using a greedy algorithm (quarter, then dime, then nickel).
- Finally pulses a clear that resets the upstream deposit accumulator. A cancel request refunds the whole deposit through the same coin-return path.

Parameters:
- PRICE, 20, item price in cents; must be a multiple of 5 and less than 2^DEP_W.
- DEP_W, 6, width of the deposit and change values in bits.

Ports:
- clk_i  in  1  system clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- deposit_i  in  DEP_W  running deposit total (cents) from the accepting stage
- buy_i  in  1  purchase request, sampled only in IDLE
- cancel_i  in  1  refund request, sampled only in IDLE; has priority over buy_i
- soda_o  out  1  one-cycle item-dispense pulse
- ret_nickle_o  out  1  one-cycle pulse, return one 5c coin
- ret_dime_o  out  1  one-cycle pulse, return one 10c coin
- ret_quarter_o  out  1  one-cycle pulse, return one 25c coin
- clear_o  out  1  one-cycle pulse; top level ORs it into the accepting stage's synchronous reset
- busy_o  out  1  high in every state except IDLE
- change_o  out  DEP_W  registered change still owed (change_q)

Behaviour:
- Reset (rst_ni low, asynchronous):
  - state goes to IDLE and change_q to 0.
  - All pulse outputs and busy_o are 0; change_o is 0.
  - Reset takes effect immediately, including mid-VEND or mid-RETURN; any pending coins are abandoned.
- State register: IDLE, VEND, RETURN, CLEAR.
- All outputs are decoded from state and change_q only. There is no combinational path from inputs to outputs.
- IDLE:
  - cancel_i=1 and deposit_i>0: change_q <= deposit_i, go to RETURN. buy_i is ignored that cycle.
  - cancel_i=1 and deposit_i=0: no action.
  - Else buy_i=1 and deposit_i>=PRICE: change_q <= deposit_i-PRICE, go to VEND.
  - buy_i=1 and deposit_i<PRICE: no action, no outputs; stay in IDLE.
- VEND:
  - soda_o=1 for exactly this one cycle.
  - Next state is RETURN if change_q>0, else CLEAR.
- RETURN: emit one coin per cycle, chosen greedily from change_q.
  - change_q>=25: ret_quarter_o=1, change_q -= 25.
  - Else change_q>=10: ret_dime_o=1, change_q -= 10.
  - Else change_q>=5: ret_nickle_o=1, change_q -= 5.
  - Else (1..4c residue, not reachable with legal coins): no coin; change_q <= 0.
  - Go to CLEAR when the updated change_q is 0; otherwise stay in RETURN.
  - At most one coin output is high in any cycle.
- CLEAR:
  - clear_o=1 for one cycle, then go to IDLE.
- Latency:
  - buy or cancel is sampled at edge N.
  - soda_o is high in cycle N+1 (buy path).
  - The first coin appears at N+2 for buy and N+1 for cancel.
  - clear_o appears one cycle after the last coin, or one cycle after soda_o when no change is owed.
- While busy_o=1:
  - buy_i, cancel_i and deposit_i are ignored.
  - Coins inserted upstream during this time are lost when clear_o fires. This is intentional; the top level gates coin acceptance with busy_o.
- Width and arithmetic:
  - Subtraction is unsigned at DEP_W.
  - The deposit_i>=PRICE comparison guarantees no underflow.
  - Maximum change is 2^DEP_W-1-PRICE.

Test Plan:
- Reset: hold rst_ni=0, then release with buy_i=1 and deposit_i=40 applied before the first edge. Required: all outputs 0 while reset is held; after release, normal vend per the buy rules.
- Exact price: deposit_i=20, buy_i pulse at edge N. Required: soda_o at N+1, no coin pulses, clear_o at N+2, busy_o high N+1..N+2, then IDLE.
- Change: deposit_i=60, buy. Required: soda_o at N+1, then ret_quarter_o at N+2, ret_dime_o at N+3, ret_nickle_o at N+4, clear_o at N+5. change_o steps 40, 15, 5, 0.
- Insufficient funds: deposit_i=15, buy_i held 3 cycles. Required: busy_o, soda_o and clear_o stay 0.
- Cancel priority: deposit_i=35, buy_i=cancel_i=1 same cycle. Required: no soda_o; ret_quarter_o at N+1, ret_dime_o at N+2, clear_o at N+3.
- Mid-return reset: deposit_i=63, buy; drop rst_ni during the first RETURN cycle. Required: coin outputs, busy_o and change_o go to 0 immediately; IDLE after release; no clear_o pulse.
